// File: rtl/procesador_fifo_up_mm_to_st.sv
// Host-to-fabric FIFO: Avalon-MM writes are buffered in an inferred RAM and replayed on an Avalon-ST source.
// Optional drop counter at address 2 is built when PROCESADOR_FIFO_UP_DROP_COUNT_EN is defined.
module procesador_fifo_up_mm_to_st #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
) (
  input  logic              wrclock,
  input  logic              reset_n,
  input  logic [1:0]        avalonmm_write_slave_address,
  input  logic              avalonmm_write_slave_write,
  input  logic [DATA_W-1:0] avalonmm_write_slave_writedata,
  input  logic              avalonmm_write_slave_read,
  output logic [31:0]       avalonmm_write_slave_readdata,
  output logic [DATA_W-1:0] avalonst_source_data,
  output logic              avalonst_source_valid,
  input  logic              avalonst_source_ready
);

  localparam int              DEPTH      = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;
  localparam logic [1:0] ADDR_DROP = 2'd2;

  // State registers
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              pf_valid_q, pf_valid_d;
  logic              src_valid_q, src_valid_d;
  logic [DATA_W-1:0] src_data_q, src_data_d;
  logic [31:0]       readdata_q, readdata_d;

  // RAM and its registered read port
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Decoded control
  logic              data_wr;
  logic              flush;
  logic              pop;
  logic              out_free;
  logic              pf_move;
  logic              ram_rd_en;
  logic              full;
  logic              push_ok;
  logic [ADDR_W:0]   ram_words;
  logic [31:0]       drop_count_rd;

  // The registered RAM read data acts as a prefetch stage feeding the output register,
  // so a stalled sink never loses an in-flight read and 1 word/cycle is sustained.
  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    data_wr   = avalonmm_write_slave_write && (avalonmm_write_slave_address == ADDR_DATA);
    flush     = avalonmm_write_slave_write && (avalonmm_write_slave_address == ADDR_CTRL)
                && avalonmm_write_slave_writedata[0];
    pop       = src_valid_q && avalonst_source_ready;
    out_free  = !src_valid_q || avalonst_source_ready;
    pf_move   = pf_valid_q && out_free;
    ram_words = level_q - (ADDR_W + 1)'(pf_valid_q) - (ADDR_W + 1)'(src_valid_q);
    ram_rd_en = (ram_words != '0) && (!pf_valid_q || out_free) && !flush;
    full      = (level_q == LEVEL_FULL);
    push_ok   = data_wr && (!full || pop);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    pf_valid_d  = pf_valid_q;
    src_valid_d = src_valid_q;
    src_data_d  = src_data_q;

    if (push_ok)   wr_ptr_d = wr_ptr_q + 1'b1;
    if (ram_rd_en) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (pf_move) begin
      src_valid_d = 1'b1;
      src_data_d  = rd_data_q;
    end else if (pop) begin
      src_valid_d = 1'b0;
    end

    if (ram_rd_en)    pf_valid_d = 1'b1;
    else if (pf_move) pf_valid_d = 1'b0;

    // Flush beats any same-cycle transfer and discards the prefetched word.
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      pf_valid_d  = 1'b0;
      src_valid_d = 1'b0;
    end
  end

`ifdef PROCESADOR_FIFO_UP_DROP_COUNT_EN
  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic        drop;

  always_comb begin
    drop       = data_wr && full && !pop;
    drop_cnt_d = drop_cnt_q;
    if (flush || (avalonmm_write_slave_write && (avalonmm_write_slave_address == ADDR_DROP)))
      drop_cnt_d = '0;
    else if (drop && (drop_cnt_q != '1))
      drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge wrclock or negedge reset_n) begin
    if (!reset_n) drop_cnt_q <= '0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count_rd = drop_cnt_q;
`else
  assign drop_count_rd = '0;
`endif

  // Status reflects the state present at the edge that samples the read.
  always_comb begin
    readdata_d = '0;
    if (avalonmm_write_slave_read) begin
      case (avalonmm_write_slave_address)
        ADDR_CTRL: begin
          readdata_d[ADDR_W:0] = level_q;
          readdata_d[30]       = full;
          readdata_d[31]       = (level_q == '0);
        end
        ADDR_DROP: readdata_d = drop_count_rd;
        default:   readdata_d = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wrclock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pf_valid_q  <= 1'b0;
      src_valid_q <= 1'b0;
      src_data_q  <= '0;
      readdata_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      pf_valid_q  <= pf_valid_d;
      src_valid_q <= src_valid_d;
      src_data_q  <= src_data_d;
      readdata_q  <= readdata_d;
    end
  end

  // NOTE: the RAM and its read register carry no reset so they map onto block RAM;
  // validity is tracked by the reset flops above, never by the stored contents.
  always_ff @(posedge wrclock) begin
    if (push_ok)   mem[wr_ptr_q] <= avalonmm_write_slave_writedata;
    if (ram_rd_en) rd_data_q     <= mem[rd_ptr_q];
  end

  assign avalonmm_write_slave_readdata = readdata_q;
  assign avalonst_source_data          = src_data_q;
  assign avalonst_source_valid         = src_valid_q;

endmodule
